// File: rtl/o_rotary_encoder_pkg.sv
// Shared phase, direction and FSM definitions for the quadrature encoder emulator and decoder.
package o_rotary_encoder_pkg;

  // Phase constants written as {a, b}.
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  // Phase issued at each quarter of a detent; element 0 is the first transition out of 00.
  localparam logic [3:0][1:0] CW_NEXT  = {PH_00, PH_01, PH_11, PH_10};
  localparam logic [3:0][1:0] CCW_NEXT = {PH_00, PH_10, PH_11, PH_01};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [1:0] quarter_phase(input logic dir, input logic [1:0] q);
    return (dir == DIR_CW) ? CW_NEXT[q] : CCW_NEXT[q];
  endfunction

endpackage

// File: rtl/o_rotary_encoder_if.sv
// Step-request / quadrature-output bundle of the encoder emulator.
// o_position exists only when O_ROTARY_ENCODER_POSITION_EN is defined.
interface o_rotary_encoder_if #(
  parameter int unsigned PENDING_WIDTH = 4
);
  typedef logic [PENDING_WIDTH-1:0] pos_t;

  logic i_step;
  logic i_step_cw;
  logic o_ready;
  logic o_busy;
  logic o_phase_a;
  logic o_phase_b;
`ifdef O_ROTARY_ENCODER_POSITION_EN
  pos_t o_position;

  modport master (
    output i_step, i_step_cw,
    input  o_ready, o_busy, o_phase_a, o_phase_b, o_position
  );
  modport slave (
    input  i_step, i_step_cw,
    output o_ready, o_busy, o_phase_a, o_phase_b, o_position
  );
`else
  modport master (
    output i_step, i_step_cw,
    input  o_ready, o_busy, o_phase_a, o_phase_b
  );
  modport slave (
    input  i_step, i_step_cw,
    output o_ready, o_busy, o_phase_a, o_phase_b
  );
`endif
endinterface

// File: rtl/o_rotary_dwell_timer.sv
// Reloadable down-counter; o_expire pulses for one cycle when a loaded count runs out.
module o_rotary_dwell_timer #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned Width = $clog2(DWELL + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  output logic             o_expire
);
  logic [Width-1:0] count_q;
  logic             armed_q;

  // Disarming on expiry keeps the strobe single-cycle unless the owner reloads.
  assign o_expire = armed_q && (count_q == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_q <= '0;
      armed_q <= 1'b0;
    end else if (i_load) begin
      count_q <= i_load_val;
      armed_q <= 1'b1;
    end else if (armed_q) begin
      if (count_q == '0) begin
        armed_q <= 1'b0;
      end else begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/o_rotary_encoder.sv
// Quadrature rotary-encoder emulator: turns step requests into complete Gray-code detent cycles.
// Optional O_ROTARY_ENCODER_POSITION_EN adds a wrapping count of completed detents.
module o_rotary_encoder
  import o_rotary_encoder_pkg::*;
#(
  parameter int unsigned DWELL         = 4,
  parameter int unsigned PENDING_WIDTH = 4
) (
  input logic               i_clk,
  input logic               i_rst_n,
  o_rotary_encoder_if.slave bus
);
  localparam int unsigned TimerW = $clog2(DWELL + 1);
  localparam logic signed [PENDING_WIDTH-1:0] PendMax =
      PENDING_WIDTH'((1 << (PENDING_WIDTH - 1)) - 1);
  localparam logic signed [PENDING_WIDTH-1:0] PendOne = PENDING_WIDTH'(1);
  localparam logic [TimerW-1:0] DwellLoad = TimerW'(DWELL - 1);

  state_e                          state_q, state_d;
  logic [1:0]                      q_q, q_d;
  logic                            zero_hold_q, zero_hold_d;
  logic                            dir_q, dir_d;
  logic [1:0]                      phase_q, phase_d;
  logic signed [PENDING_WIDTH-1:0] pending_q, pending_d;
  logic signed [PENDING_WIDTH-1:0] req, pend_sum;
  logic                            ready, accept, can_commit, commit, commit_dir;
  logic                            timer_load, timer_expire;
  logic [TimerW-1:0]               timer_val;

  assign ready      = (pending_q != PendMax) && (pending_q != -PendMax);
  assign accept     = bus.i_step && ready;
  assign req        = !accept ? '0 : (bus.i_step_cw ? PendOne : -PendOne);
  assign pend_sum   = pending_q + req;
  // An opposing request arriving with the last uncommitted detent cancels it instead.
  assign can_commit = (pending_q != '0) && (pend_sum != '0);
  assign commit_dir = pending_q[PENDING_WIDTH-1] ? DIR_CCW : DIR_CW;

  o_rotary_dwell_timer #(
    .DWELL (DWELL),
    .Width (TimerW)
  ) u_dwell_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (timer_load),
    .i_load_val (timer_val),
    .o_expire   (timer_expire)
  );

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    zero_hold_d = zero_hold_q;
    dir_d       = dir_q;
    phase_d     = phase_q;
    commit      = 1'b0;
    timer_load  = 1'b0;
    timer_val   = DwellLoad;

    unique case (state_q)
      ST_IDLE: begin
        if (can_commit) begin
          commit      = 1'b1;
          dir_d       = commit_dir;
          state_d     = ST_RUN;
          q_d         = 2'd0;
          zero_hold_d = 1'b0;
          timer_load  = 1'b1;
          timer_val   = '0;
        end
      end
      ST_RUN: begin
        if (timer_expire) begin
          if (!zero_hold_q) begin
            phase_d    = quarter_phase(dir_q, q_q);
            q_d        = q_q + 2'd1;
            timer_load = 1'b1;
            if (q_q == 2'd3) begin
              zero_hold_d = 1'b1;
            end
          end else if (can_commit) begin
            // Back-to-back detent: the end of the 00 hold is the next detent's first edge.
            commit      = 1'b1;
            dir_d       = commit_dir;
            phase_d     = quarter_phase(commit_dir, 2'd0);
            q_d         = 2'd1;
            zero_hold_d = 1'b0;
            timer_load  = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            q_d         = 2'd0;
            zero_hold_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pending_d = pend_sum;
    if (commit) begin
      pending_d = (commit_dir == DIR_CW) ? pend_sum - PendOne : pend_sum + PendOne;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      q_q         <= 2'd0;
      zero_hold_q <= 1'b0;
      dir_q       <= DIR_CW;
      phase_q     <= PH_00;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      zero_hold_q <= zero_hold_d;
      dir_q       <= dir_d;
      phase_q     <= phase_d;
      pending_q   <= pending_d;
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_busy    = (state_q == ST_RUN);
  assign bus.o_phase_a = phase_q[1];
  assign bus.o_phase_b = phase_q[0];

`ifdef O_ROTARY_ENCODER_POSITION_EN
  logic [PENDING_WIDTH-1:0] position_q;
  logic                     pos_step;

  // Counted on the edge that issues the final 00 of a detent.
  assign pos_step = (state_q == ST_RUN) && timer_expire && !zero_hold_q && (q_q == 2'd3);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      position_q <= '0;
    end else if (pos_step) begin
      position_q <= (dir_q == DIR_CW) ? position_q + PENDING_WIDTH'(1)
                                      : position_q - PENDING_WIDTH'(1);
    end
  end

  assign bus.o_position = position_q;
`endif

endmodule
